// File: rtl/rfphoenix_vrf_wb_arbiter_pkg.sv
// Shared types for the vector register file write-back path.
// Provides the lane, thread and register geometry, the WbReq bundle and the wb_state_e enum.
package rfPhoenixPkg;

  localparam int NLANES   = 16;
  localparam int NTHREADS = 16;
  localparam int NREGS    = 64;

  localparam int TW   = 4;
  localparam int RW   = 6;
  localparam int VALW = 32;
  localparam int VW   = NLANES * VALW;
  localparam int CW   = TW + RW;

  localparam logic [CW-1:0] SWEEP_LAST =
    CW'(NTHREADS * NREGS - 1);

  typedef logic [RW-1:0]   Regspec;
  typedef logic [VALW-1:0] Value;
  typedef logic [NLANES-1:0][VALW-1:0] VecValue;

  typedef struct packed {
    logic [TW-1:0]     thread;
    Regspec            wa;
    logic [NLANES-1:0] wmask;
    VecValue           data;
  } WbReq;

  typedef enum logic {
    WB_CLEAR,
    WB_RUN
  } wb_state_e;

  function automatic int rr_wrap(
    input int base,
    input int off,
    input int n
  );
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rfphoenix_rr_picker.sv
// Round-robin picker: first set bit of i_req at or above i_ptr, wrapping.
// Ports: i_req, i_ptr in; o_gnt (one-hot), o_idx, o_any out.
module rfphoenix_rr_picker
  import rfPhoenixPkg::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    int k;
    k     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = rr_wrap(int'(i_ptr), i, NREQ);
      if (!o_any && i_req[k]) begin
        o_any    = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/rfphoenix_vrf_wb_arbiter.sv
// Write-back scheduler for the VRF write port: round-robin over NREQ
// requesters with a registered write, plus a zeroing sweep after reset
// or on clear_req. Ports: clk, rst (async, active-low), req_* bundle in,
// req_ready out, clear_req in, busy out, wr/wthread/wmask/wa/wdata out.
// Build option RFPHOENIX_WB_MERGE_EN merges lane-disjoint writes to the
// same thread/register into one cycle.
module rfphoenix_vrf_wb_arbiter
  import rfPhoenixPkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*TW-1:0]     req_thread,
  input  logic [NREQ*NLANES-1:0] req_wmask,
  input  logic [NREQ*RW-1:0]     req_wa,
  input  logic [NREQ*VW-1:0]     req_data,
  input  logic                   clear_req,
  output logic                   busy,
  output logic                   wr,
  output logic [TW-1:0]          wthread,
  output logic [NLANES-1:0]      wmask,
  output logic [RW-1:0]          wa,
  output logic [VW-1:0]          wdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_state_e         r_state;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_rr;

  WbReq              w_req [NREQ];
  logic              w_run_ok;
  logic [NREQ-1:0]   w_vld;
  logic [NREQ-1:0]   w_win_gnt;
  logic [PW-1:0]     w_win_idx;
  logic              w_any;
  logic [NREQ-1:0]   w_gnt;
  logic [NLANES-1:0] w_mask;
  VecValue           w_data;
  logic [PW-1:0]     w_last;
  logic [CW-1:0]     w_addr;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      w_req[k].thread = req_thread[k*TW +: TW];
      w_req[k].wa     = req_wa[k*RW +: RW];
      w_req[k].wmask  = req_wmask[k*NLANES +: NLANES];
      w_req[k].data   = req_data[k*VW +: VW];
    end
  end

  // Grants only in RUN, and never in the cycle a clear is requested.
  assign w_run_ok = (r_state == WB_RUN) && !clear_req;
  assign w_vld    = req_valid & {NREQ{w_run_ok}};

  rfphoenix_rr_picker #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req (w_vld),
    .i_ptr (r_rr),
    .o_gnt (w_win_gnt),
    .o_idx (w_win_idx),
    .o_any (w_any)
  );

`ifdef RFPHOENIX_WB_MERGE_EN
  // Walk the rest of the ring in rr order after the winner; take any
  // same-target request whose lanes don't collide with what's taken.
  always_comb begin
    int k;
    k      = 0;
    w_gnt  = w_win_gnt;
    w_mask = w_req[w_win_idx].wmask;
    w_data = w_req[w_win_idx].data;
    w_last = w_win_idx;
    for (int i = 1; i < NREQ; i++) begin
      k = rr_wrap(int'(w_win_idx), i, NREQ);
      if (w_any && w_vld[k] &&
          w_req[k].thread == w_req[w_win_idx].thread &&
          w_req[k].wa == w_req[w_win_idx].wa &&
          (w_req[k].wmask & w_mask) == '0) begin
        w_gnt[k] = 1'b1;
        w_mask   = w_mask | w_req[k].wmask;
        for (int l = 0; l < NLANES; l++) begin
          if (w_req[k].wmask[l]) begin
            w_data[l] = w_req[k].data[l];
          end
        end
        w_last = PW'(k);
      end
    end
  end
`else
  assign w_gnt  = w_win_gnt;
  assign w_mask = w_req[w_win_idx].wmask;
  assign w_data = w_req[w_win_idx].data;
  assign w_last = w_win_idx;
`endif

  assign req_ready = w_gnt;
  assign busy      = (r_state == WB_CLEAR);

  // A clear pulse during the sweep restarts it from entry 0 this cycle.
  assign w_addr = clear_req ? '0 : r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WB_CLEAR;
      r_cnt   <= '0;
      r_rr    <= '0;
      wr      <= 1'b0;
      wthread <= '0;
      wmask   <= '0;
      wa      <= '0;
      wdata   <= '0;
    end else begin
      unique case (r_state)
        WB_CLEAR: begin
          wr             <= 1'b1;
          {wthread, wa}  <= w_addr;
          wmask          <= '1;
          wdata          <= '0;
          r_cnt          <= w_addr + CW'(1);
          if (w_addr == SWEEP_LAST) begin
            r_state <= WB_RUN;
          end
        end
        WB_RUN: begin
          if (clear_req) begin
            wr      <= 1'b0;
            r_cnt   <= '0;
            r_state <= WB_CLEAR;
          end else begin
            wr <= w_any;
            if (w_any) begin
              wthread <= w_req[w_win_idx].thread;
              wa      <= w_req[w_win_idx].wa;
              wmask   <= w_mask;
              wdata   <= w_data;
              r_rr    <= PW'(rr_wrap(int'(w_last), 1, NREQ));
            end
          end
        end
        default: begin
          r_state <= WB_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: doc/rfphoenix_vrf_wb_arbiter.md
Name: rfphoenix_vrf_wb_arbiter

Overview:
Write-back scheduler for the vector register file's single write port. It shares the port between NREQ functional-unit requesters using round-robin arbitration, and drives one registered write per cycle with per-lane write mask. After reset, or on request, it runs a clear sweep that zeroes every thread/register entry before normal writeback resumes.

Parameters:
NREQ, 4, number of writeback requesters (2..8)
NLANES, 16, vector lanes; width of write mask
NTHREADS, 16, hardware threads; thread id width 4
NREGS, 64, registers per thread; Regspec width 6

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
req_valid  in  NREQ  requester k has a write pending
req_ready  out  NREQ  requester k granted this cycle (combinational)
req_thread  in  NREQ*4  target thread per requester
req_wmask  in  NREQ*NLANES  lane write mask per requester
req_wa  in  NREQ*6  target Regspec per requester
req_data  in  NREQ*VecValue  write data per requester
clear_req  in  1  one-cycle pulse: start a new clear sweep
busy  out  1  high while in CLEAR
wr  out  1  register-file write enable
wthread  out  4  register-file write thread
wmask  out  NLANES  register-file lane mask
wa  out  6  register-file write Regspec
wdata  out  VecValue  register-file write data

Behaviour:
- Reset (rst=0, asynchronous): state=CLEAR, sweep counter=0, rr pointer=0; wr=0, wthread=0, wmask=0, wa=0, wdata=0, busy=1, req_ready=0.
- FSM states: CLEAR, RUN.
- CLEAR: each cycle registers wr=1, {wthread,wa}=counter, wmask=all ones, wdata=0; counter increments by 1.
  - After counter reaches NTHREADS*NREGS-1 (1023 by default), the next state is RUN.
  - A full sweep is exactly 1024 write cycles; req_ready=0 throughout; busy=1.
- RUN: busy=0.
  - Winner = first k with req_valid[k]=1, searching from rr pointer upward with wrap modulo NREQ.
  - req_ready[winner]=1 in the same cycle; transfer occurs when valid&ready.
  - Next edge registers wr=1 plus the winner's thread, wa, mask and data. Latency is 1 cycle from transfer to wr.
  - rr pointer becomes winner+1 (mod NREQ).
  - No valid requester: wr=0 next cycle; rr pointer unchanged.
- Handshake: requester holds valid and all payload stable until ready. ready never asserts without valid. Max wait for any requester is NREQ-1 grants.
- req_wmask=0 with valid: still granted; wr=1 with wmask=0 (harmless, keeps ordering).
- clear_req in RUN: no grant that cycle. Next state=CLEAR, counter=0. A write already registered completes normally.
- clear_req in CLEAR: counter restarts at 0.
- Reset mid-sweep or mid-transfer: immediate return to reset values; an in-flight grant is lost, and requesters re-present after reset.
- Outputs wr..wdata are flops only, with no combinational path from req_* to them.

Optional Feature:
Macro RFPHOENIX_WB_MERGE_EN.
- Defined: after selecting the winner, every other valid requester with the same thread and wa whose mask is disjoint from the accumulated mask is also granted in that cycle, in rr order.
  - Registered wmask = OR of the granted masks.
  - wdata lane g comes from the granted requester whose mask bit g is set.
  - Overlapping masks are not merged; that requester waits.
  - rr pointer = last granted index+1.
- Undefined: strictly one grant per cycle; no merge logic synthesized.

Decomposition:
- rfPhoenixPkg: NLANES, NTHREADS, NREGS, Regspec, Value, VecValue; add a WbReq struct (thread, wa, wmask, data) and typedef for state enum {WB_CLEAR, WB_RUN}.
- One natural sub-module: rfphoenix_rr_picker (NREQ-bit request vector + pointer -> one-hot grant), reused by other round-robin arbiters.

Test Plan:
- Reset release, no requests -> exactly 1024 consecutive wr=1 cycles with {wthread,wa} 0..1023, wmask=16'hFFFF, wdata=0; busy falls the cycle after address 1023.
- RUN, only req1 valid (thread 3, wa 5, mask 16'h00F0, data pattern A) -> req_ready[1] same cycle; next cycle wr=1, wthread=3, wa=5, wmask=16'h00F0, wdata=A.
- All four valid continuously from rr=0 -> grant order 0,1,2,3,0,1; one wr per cycle; no requester skipped.
- req2 valid while clear_req pulses -> req_ready[2]=0; a 1024-cycle sweep runs; req2 is granted on the first RUN cycle with payload unchanged.
- rst driven low mid-sweep at counter 300 -> wr=0 asynchronously; after release the sweep restarts at address 0.
- Merge enabled: req0 and req3 both target thread 1, wa 9, masks 16'h000F and 16'hF000 -> both ready in the same cycle; wmask=16'hF00F with lanes from the respective sources. Masks 16'h00FF and 16'h0F0F -> only one granted.
